// File: rtl/counter_time_prog_pkg.sv
// Shared game-timing definitions: FSM state encoding, mode constants and
// the prescaler width helper.
package counter_time_prog_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    // Prescaler counter width; a divide-by-1 still keeps a 1-bit register.
    function automatic int presc_width(input int presc);
        return (presc > 1) ? $clog2(presc) : 1;
    endfunction

endpackage

// File: rtl/counter_time_prog_prescaler_tick.sv
// Divide-by-PRESC tick generator. tick is combinational on enable so that
// the count step lands on the same edge the last prescaler phase completes.
// With PRESC=1 the counter never leaves 0 and tick degenerates to enable.
module prescaler_tick
    import counter_time_prog_pkg::*;
#(
    parameter int PRESC = 1
) (
    input  logic CLKT,
    input  logic R_N,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int              PW   = presc_width(PRESC);
    localparam logic [PW-1:0]   LAST = PW'(PRESC - 1);

    logic [PW-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    // Phase counter: cleared on restart/abort, frozen while disabled.
    always_ff @(posedge CLKT or negedge R_N) begin
        if (!R_N) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick ? '0 : cnt + PW'(1);
        end
    end

endmodule

// File: rtl/counter_time_prog.sv
// Programmable game timer: counts 0..limit_q, one step per PRESC enabled
// clocks, one-shot or periodic, with a wrap pulse and a sticky expiry flag.
module counter_time_prog
    import counter_time_prog_pkg::*;
#(
    parameter int SIZE  = 4,
    parameter int PRESC = 1
) (
    input  logic            CLKT,
    input  logic            R_N,
    input  logic            E,
    input  logic            START,
    input  logic            STOP,
    input  logic            MODE,
    input  logic [SIZE-1:0] LIMIT,
    output logic [SIZE-1:0] TEMPO,
    output logic            end_time,
    output logic            RUNNING,
    output logic            EXPIRED
);

    state_t          state;
    logic [SIZE-1:0] tempo_q;
    logic [SIZE-1:0] limit_q;
    logic            mode_q;
    logic            end_q;
    logic            run_q;
    logic            exp_q;
    logic            tick;
    logic            presc_clear;
    logic            presc_en;

    // Prescaler only advances while counting; any control request or
    // leaving RUN resets its phase so the next run starts aligned.
    assign presc_clear = STOP || START || (state != RUN);
    assign presc_en    = E && (state == RUN);

    prescaler_tick #(.PRESC(PRESC)) u_presc (
        .CLKT   (CLKT),
        .R_N    (R_N),
        .clear  (presc_clear),
        .enable (presc_en),
        .tick   (tick)
    );

    // Control FSM with registered count and flags; STOP > START > count.
    always_ff @(posedge CLKT or negedge R_N) begin
        if (!R_N) begin
            state   <= IDLE;
            tempo_q <= '0;
            limit_q <= '0;
            mode_q  <= MODE_ONESHOT;
            end_q   <= 1'b0;
            run_q   <= 1'b0;
            exp_q   <= 1'b0;
        end else begin
            end_q <= 1'b0;
            if (STOP) begin
                state   <= IDLE;
                tempo_q <= '0;
                run_q   <= 1'b0;
                exp_q   <= 1'b0;
            end else if (START) begin
                state   <= RUN;
                limit_q <= LIMIT;
                mode_q  <= MODE;
                tempo_q <= '0;
                run_q   <= 1'b1;
                exp_q   <= 1'b0;
            end else if (state == RUN && tick) begin
                // Wrap by explicit compare so LIMIT=2^SIZE-1 never relies on overflow.
                if (tempo_q == limit_q) begin
                    tempo_q <= '0;
                    end_q   <= 1'b1;
                    if (mode_q != MODE_PERIODIC) begin
                        state <= DONE;
                        run_q <= 1'b0;
                        exp_q <= 1'b1;
                    end
                end else begin
                    tempo_q <= tempo_q + SIZE'(1);
                end
            end
        end
    end

    assign TEMPO    = tempo_q;
    assign end_time = end_q;
    assign RUNNING  = run_q;
    assign EXPIRED  = exp_q;

endmodule

// File: tb/tb_counter_time_prog.sv
// Bench for counter_time_prog: three instances (PRESC 1, 3, 4) share the
// same stimulus and are compared every cycle against a model that tracks
// only the number of enabled cycles since START and derives the count from it.
module tb_counter_time_prog;

    logic       CLKT = 1'b0;
    logic       R_N  = 1'b0;
    logic       E = 1'b0, START = 1'b0, STOP = 1'b0, MODE = 1'b0;
    logic [3:0] LIMIT = 4'd0;

    logic [3:0] tempo_o [3];
    logic       et_o    [3];
    logic       run_o   [3];
    logic       exp_o   [3];

    int npass = 0;
    int ntotal = 0;
    int cycn = 0;

    // Model state per instance.
    int pv    [3] = '{1, 3, 4};
    int m_k   [3];
    int m_lim [3];
    bit m_run [3];
    bit m_exp [3];
    bit m_et  [3];
    bit m_md  [3];

    always #5 CLKT = ~CLKT;

    counter_time_prog #(.SIZE(4), .PRESC(1)) dut1 (
        .CLKT(CLKT), .R_N(R_N), .E(E), .START(START), .STOP(STOP), .MODE(MODE),
        .LIMIT(LIMIT), .TEMPO(tempo_o[0]), .end_time(et_o[0]), .RUNNING(run_o[0]),
        .EXPIRED(exp_o[0]));
    counter_time_prog #(.SIZE(4), .PRESC(3)) dut3 (
        .CLKT(CLKT), .R_N(R_N), .E(E), .START(START), .STOP(STOP), .MODE(MODE),
        .LIMIT(LIMIT), .TEMPO(tempo_o[1]), .end_time(et_o[1]), .RUNNING(run_o[1]),
        .EXPIRED(exp_o[1]));
    counter_time_prog #(.SIZE(4), .PRESC(4)) dut4 (
        .CLKT(CLKT), .R_N(R_N), .E(E), .START(START), .STOP(STOP), .MODE(MODE),
        .LIMIT(LIMIT), .TEMPO(tempo_o[2]), .end_time(et_o[2]), .RUNNING(run_o[2]),
        .EXPIRED(exp_o[2]));

    function automatic logic [6:0] obsv(input int i);
        return {tempo_o[i], et_o[i], run_o[i], exp_o[i]};
    endfunction

    // Expected {TEMPO, end_time, RUNNING, EXPIRED}: count = steps mod (limit+1).
    function automatic logic [6:0] expv(input int i);
        int t;
        t = m_run[i] ? (m_k[i] / pv[i]) % (m_lim[i] + 1) : 0;
        return {t[3:0], m_et[i], m_run[i], m_exp[i]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_k[i] = 0; m_lim[i] = 0; m_run[i] = 0; m_exp[i] = 0; m_et[i] = 0; m_md[i] = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            m_et[i] = 0;
            if (STOP) begin
                m_run[i] = 0; m_exp[i] = 0; m_k[i] = 0;
            end else if (START) begin
                m_run[i] = 1; m_exp[i] = 0; m_k[i] = 0;
                m_lim[i] = int'(LIMIT); m_md[i] = MODE;
            end else if (m_run[i] && E) begin
                m_k[i]++;
                if (m_k[i] % pv[i] == 0 && (m_k[i] / pv[i]) % (m_lim[i] + 1) == 0) begin
                    m_et[i] = 1;
                    if (!m_md[i]) begin
                        m_run[i] = 0; m_exp[i] = 1;
                    end
                end
            end
        end
    endtask

    // One clock: inputs applied at negedge, model advanced at posedge,
    // return at the following negedge where outputs are sampled.
    task automatic cyc(input logic e, input logic st, input logic sp,
                       input logic md, input logic [3:0] lm);
        E = e; START = st; STOP = sp; MODE = md; LIMIT = lm;
        @(posedge CLKT);
        model_edge();
        @(negedge CLKT);
        cycn++;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            ntotal++;
            if (obsv(i) !== 7'd0) $display("FAIL reset_init inst%0d: got %b expected %b", i, obsv(i), 7'd0);
            else npass++;
        end
        cyc(1, 1, 0, 1, 4'd9);
        for (int c = 0; c < 5; c++) cyc(1, 0, 0, 1, 4'd9);
        ntotal++;
        if (tempo_o[0] !== 4'd5) $display("FAIL reset_pre_tempo: got %0d expected 5", tempo_o[0]);
        else npass++;
        #2 R_N = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            ntotal++;
            if (obsv(i) !== expv(i)) $display("FAIL reset_midcount inst%0d: got %b expected %b", i, obsv(i), expv(i));
            else npass++;
        end
        @(negedge CLKT);
        R_N = 1'b1;
        // STOP in IDLE has no effect.
        cyc(1, 0, 1, 0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            ntotal++;
            if (obsv(i) !== 7'd0) $display("FAIL stop_idle inst%0d: got %b expected %b", i, obsv(i), 7'd0);
            else npass++;
        end
    endtask

    task automatic test_periodic_legacy();
        int pulses = 0;
        cyc(1, 1, 0, 1, 4'd9);
        for (int c = 1; c <= 30; c++) begin
            cyc(1, 0, 0, 1, 4'd9);
            if (et_o[0] === 1'b1) pulses++;
            ntotal++;
            if (tempo_o[0] !== 4'(c % 10)) $display("FAIL legacy_tempo cycle %0d: got %0d expected %0d", c, tempo_o[0], c % 10);
            else npass++;
            for (int i = 0; i < 3; i++) begin
                ntotal++;
                if (obsv(i) !== expv(i)) $display("FAIL legacy inst%0d cycle %0d: got %b expected %b", i, c, obsv(i), expv(i));
                else npass++;
            end
        end
        ntotal++;
        if (pulses != 3) $display("FAIL legacy_pulses: got %0d expected 3", pulses);
        else npass++;
    endtask

    task automatic test_oneshot_prescale();
        int pulses = 0;
        cyc(1, 1, 0, 0, 4'd3);
        for (int c = 1; c <= 24; c++) begin
            cyc(1, 0, 0, 0, 4'd3);
            if (et_o[2] === 1'b1) pulses++;
            if (c == 16) begin
                ntotal++;
                if ({tempo_o[2], et_o[2], run_o[2], exp_o[2]} !== {4'd0, 1'b1, 1'b0, 1'b1})
                    $display("FAIL oneshot_end: got %b expected %b", obsv(2), {4'd0, 1'b1, 1'b0, 1'b1});
                else npass++;
            end
            for (int i = 0; i < 3; i++) begin
                ntotal++;
                if (obsv(i) !== expv(i)) $display("FAIL oneshot inst%0d cycle %0d: got %b expected %b", i, c, obsv(i), expv(i));
                else npass++;
            end
        end
        ntotal++;
        if (pulses != 1) $display("FAIL oneshot_pulses: got %0d expected 1", pulses);
        else npass++;
    endtask

    task automatic test_pause();
        cyc(1, 1, 0, 1, 4'd5);
        for (int c = 0; c < 7; c++) cyc(1, 0, 0, 1, 4'd5);
        for (int c = 0; c < 7; c++) begin
            cyc(0, 0, 0, 1, 4'd5);
            ntotal++;
            if ({tempo_o[1], run_o[1]} !== {4'd2, 1'b1}) $display("FAIL pause_hold cycle %0d: got %b expected %b", c, {tempo_o[1], run_o[1]}, {4'd2, 1'b1});
            else npass++;
        end
        cyc(1, 0, 0, 1, 4'd5);
        ntotal++;
        if (tempo_o[1] !== 4'd2) $display("FAIL pause_resume1: got %0d expected 2", tempo_o[1]);
        else npass++;
        cyc(1, 0, 0, 1, 4'd5);
        ntotal++;
        if (tempo_o[1] !== 4'd3) $display("FAIL pause_resume2: got %0d expected 3", tempo_o[1]);
        else npass++;
        for (int i = 0; i < 3; i++) begin
            ntotal++;
            if (obsv(i) !== expv(i)) $display("FAIL pause inst%0d: got %b expected %b", i, obsv(i), expv(i));
            else npass++;
        end
    endtask

    task automatic test_priority();
        int maxt = 0;
        cyc(1, 1, 1, 1, 4'd9);
        for (int i = 0; i < 3; i++) begin
            ntotal++;
            if (obsv(i) !== 7'd0) $display("FAIL start_stop inst%0d: got %b expected %b", i, obsv(i), 7'd0);
            else npass++;
        end
        cyc(1, 1, 0, 1, 4'd9);
        for (int c = 0; c < 25; c++) begin
            cyc(1, 0, 0, 0, 4'd2);
            if (int'(tempo_o[0]) > maxt) maxt = int'(tempo_o[0]);
            for (int i = 0; i < 3; i++) begin
                ntotal++;
                if (obsv(i) !== expv(i)) $display("FAIL limit_sample inst%0d cycle %0d: got %b expected %b", i, c, obsv(i), expv(i));
                else npass++;
            end
        end
        ntotal++;
        if (maxt != 9) $display("FAIL limit_sample_max: got %0d expected 9", maxt);
        else npass++;
        // Reach DONE on every instance, then restart.
        cyc(1, 1, 0, 0, 4'd1);
        for (int c = 0; c < 10; c++) cyc(1, 0, 0, 0, 4'd1);
        ntotal++;
        if ({exp_o[0], exp_o[1], exp_o[2]} !== 3'b111) $display("FAIL done_reached: got %b expected 111", {exp_o[0], exp_o[1], exp_o[2]});
        else npass++;
        cyc(1, 1, 0, 0, 4'd1);
        for (int i = 0; i < 3; i++) begin
            ntotal++;
            if (obsv(i) !== {4'd0, 1'b0, 1'b1, 1'b0}) $display("FAIL start_in_done inst%0d: got %b expected %b", i, obsv(i), {4'd0, 1'b0, 1'b1, 1'b0});
            else npass++;
        end
        // START coinciding with PRESC=1 terminal tick suppresses end_time.
        cyc(1, 0, 0, 1, 4'd1);
        cyc(1, 1, 0, 1, 4'd1);
        ntotal++;
        if ({tempo_o[0], et_o[0], run_o[0]} !== {4'd0, 1'b0, 1'b1}) $display("FAIL start_vs_wrap: got %b expected %b", {tempo_o[0], et_o[0], run_o[0]}, {4'd0, 1'b0, 1'b1});
        else npass++;
        // STOP out of DONE clears EXPIRED.
        cyc(1, 1, 0, 0, 4'd0);
        cyc(1, 0, 0, 0, 4'd0);
        ntotal++;
        if (exp_o[0] !== 1'b1) $display("FAIL done_lim0: got %b expected 1", exp_o[0]);
        else npass++;
        cyc(1, 0, 1, 0, 4'd0);
        for (int i = 0; i < 3; i++) begin
            ntotal++;
            if (obsv(i) !== 7'd0) $display("FAIL stop_in_done inst%0d: got %b expected %b", i, obsv(i), 7'd0);
            else npass++;
        end
    endtask

    task automatic test_boundary();
        int maxt = 0;
        int pulses = 0;
        cyc(1, 1, 0, 1, 4'd0);
        for (int c = 0; c < 8; c++) begin
            cyc(1, 0, 0, 1, 4'd0);
            ntotal++;
            if ({tempo_o[0], et_o[0]} !== {4'd0, 1'b1}) $display("FAIL limit0 cycle %0d: got %b expected %b", c, {tempo_o[0], et_o[0]}, {4'd0, 1'b1});
            else npass++;
        end
        cyc(1, 1, 0, 1, 4'd15);
        for (int c = 1; c <= 20; c++) begin
            cyc(1, 0, 0, 1, 4'd15);
            if (int'(tempo_o[0]) > maxt) maxt = int'(tempo_o[0]);
            if (et_o[0] === 1'b1) pulses++;
            for (int i = 0; i < 3; i++) begin
                ntotal++;
                if (obsv(i) !== expv(i)) $display("FAIL limit15 inst%0d cycle %0d: got %b expected %b", i, c, obsv(i), expv(i));
                else npass++;
            end
        end
        ntotal++;
        if (maxt != 15 || pulses != 1) $display("FAIL limit15_wrap: got max %0d pulses %0d expected max 15 pulses 1", maxt, pulses);
        else npass++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            cyc(logic'($urandom_range(3, 0) != 0), logic'($urandom_range(39, 0) == 0),
                logic'($urandom_range(59, 0) == 0), logic'($urandom_range(1, 0)),
                4'($urandom_range(15, 0)));
            for (int i = 0; i < 3; i++) begin
                ntotal++;
                if (obsv(i) !== expv(i)) $display("FAIL random inst%0d cycle %0d: got %b expected %b", i, c, obsv(i), expv(i));
                else npass++;
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge CLKT);
        R_N = 1'b1;
        test_reset();
        test_periodic_legacy();
        test_oneshot_prescale();
        test_pause();
        test_priority();
        test_boundary();
        test_random();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
